// File: rtl/rggen_axi4lite_regbus_bridge.sv
// Converts buffered AXI4-Lite AW/W/AR into single register-bus accesses and returns B/R.
// One access in flight in total; read/write round-robin when both are pending.
module rggen_axi4lite_regbus_bridge #(
    parameter int ID_WIDTH        = 0,
    parameter int ADDRESS_WIDTH   = 8,
    parameter int BUS_WIDTH       = 32,
    parameter int ACTUAL_ID_WIDTH = (ID_WIDTH > 0) ? ID_WIDTH : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_awvalid,
    output logic                       o_awready,
    input  logic [ACTUAL_ID_WIDTH-1:0] i_awid,
    input  logic [ADDRESS_WIDTH-1:0]   i_awaddr,
    input  logic [2:0]                 i_awprot,
    input  logic                       i_wvalid,
    output logic                       o_wready,
    input  logic [BUS_WIDTH-1:0]       i_wdata,
    input  logic [BUS_WIDTH/8-1:0]     i_wstrb,
    output logic                       o_bvalid,
    input  logic                       i_bready,
    output logic [ACTUAL_ID_WIDTH-1:0] o_bid,
    output logic [1:0]                 o_bresp,
    input  logic                       i_arvalid,
    output logic                       o_arready,
    input  logic [ACTUAL_ID_WIDTH-1:0] i_arid,
    input  logic [ADDRESS_WIDTH-1:0]   i_araddr,
    input  logic [2:0]                 i_arprot,
    output logic                       o_rvalid,
    input  logic                       i_rready,
    output logic [ACTUAL_ID_WIDTH-1:0] o_rid,
    output logic [1:0]                 o_rresp,
    output logic [BUS_WIDTH-1:0]       o_rdata,
    output logic                       o_bus_valid,
    output logic [1:0]                 o_bus_access,
    output logic [ADDRESS_WIDTH-1:0]   o_bus_address,
    output logic [BUS_WIDTH-1:0]       o_bus_write_data,
    output logic [BUS_WIDTH/8-1:0]     o_bus_strobe,
    input  logic                       i_bus_ready,
    input  logic [1:0]                 i_bus_status,
    input  logic [BUS_WIDTH-1:0]       i_bus_read_data
);
    localparam int STRB_WIDTH = BUS_WIDTH / 8;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic                         r_rr_write;
    logic                         r_write;
    logic [ACTUAL_ID_WIDTH-1:0]   r_id;
    logic [ADDRESS_WIDTH-1:0]     r_address;
    logic [BUS_WIDTH-1:0]         r_write_data;
    logic [STRB_WIDTH-1:0]        r_strobe;
    logic [1:0]                   r_status;
    logic [BUS_WIDTH-1:0]         r_read_data;

    logic                         w_idle;
    logic                         w_write_pending;
    logic                         w_read_pending;
    logic                         w_grant_write;
    logic                         w_grant_read;
    logic                         w_bus_done;
    logic                         w_resp_done;
    logic [ACTUAL_ID_WIDTH-1:0]   w_awid;
    logic [ACTUAL_ID_WIDTH-1:0]   w_arid;
    logic                         w_unused;

    // Without IDs the 1-bit id ports are ignored and responses carry 0.
    if (ID_WIDTH > 0) begin : g_id
        assign w_awid = i_awid;
        assign w_arid = i_arid;
    end else begin : g_no_id
        assign w_awid = '0;
        assign w_arid = '0;
    end

    assign w_unused = ^{i_awprot, i_arprot, i_awid, i_arid};

    // Readies are gated by reset so nothing is accepted while the state is held.
    assign w_idle          = (r_state == StIdle) && i_rst_n;
    assign w_write_pending = i_awvalid && i_wvalid;
    assign w_read_pending  = i_arvalid;
    assign w_grant_write   = w_idle && w_write_pending && (!w_read_pending || r_rr_write);
    assign w_grant_read    = w_idle && w_read_pending && (!w_write_pending || !r_rr_write);
    assign w_bus_done      = (r_state == StBus) && i_bus_ready;
    assign w_resp_done     = (r_state == StResp) && (r_write ? i_bready : i_rready);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_grant_write || w_grant_read) begin
                    w_state_next = StBus;
                end
            end
            StBus: begin
                if (w_bus_done) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                if (w_resp_done) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pointer names the direction preferred at the next contended grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_write <= 1'b1;
        end else if (w_grant_write) begin
            r_rr_write <= 1'b0;
        end else if (w_grant_read) begin
            r_rr_write <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_write      <= 1'b0;
            r_id         <= '0;
            r_address    <= '0;
            r_write_data <= '0;
            r_strobe     <= '0;
        end else if (w_grant_write) begin
            r_write      <= 1'b1;
            r_id         <= w_awid;
            r_address    <= i_awaddr;
            r_write_data <= i_wdata;
            r_strobe     <= i_wstrb;
        end else if (w_grant_read) begin
            r_write      <= 1'b0;
            r_id         <= w_arid;
            r_address    <= i_araddr;
            r_write_data <= '0;
            r_strobe     <= '1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_status    <= 2'b00;
            r_read_data <= '0;
        end else if (w_bus_done) begin
            r_status    <= (i_bus_status == 2'b01) ? 2'b00 : i_bus_status;
            r_read_data <= r_write ? '0 : i_bus_read_data;
        end
    end

    assign o_awready = w_grant_write;
    assign o_wready  = w_grant_write;
    assign o_arready = w_grant_read;

    assign o_bus_valid      = (r_state == StBus);
    assign o_bus_access     = o_bus_valid ? {1'b1, r_write} : 2'b00;
    assign o_bus_address    = o_bus_valid ? r_address : '0;
    assign o_bus_write_data = o_bus_valid ? r_write_data : '0;
    assign o_bus_strobe     = o_bus_valid ? r_strobe : '0;

    assign o_bvalid = (r_state == StResp) && r_write;
    assign o_bid    = o_bvalid ? r_id : '0;
    assign o_bresp  = o_bvalid ? r_status : 2'b00;

    assign o_rvalid = (r_state == StResp) && !r_write;
    assign o_rid    = o_rvalid ? r_id : '0;
    assign o_rresp  = o_rvalid ? r_status : 2'b00;
    assign o_rdata  = o_rvalid ? r_read_data : '0;

endmodule

// File: tb/tb_rggen_axi4lite_regbus_bridge.sv
// Scoreboard bench for the AXI4-Lite to register-bus bridge: directed accesses push expected
// bus requests and B/R responses; a monitor compares whenever the DUT presents them.
module tb_rggen_axi4lite_regbus_bridge;
    typedef struct packed {
        logic [1:0]  acc;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } bus_exp_t;

    typedef struct packed {
        int          waits;
        logic [1:0]  status;
        logic [31:0] rdata;
    } bus_rsp_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_awvalid = 1'b0, i_wvalid = 1'b0, i_arvalid = 1'b0;
    logic        i_bready = 1'b1, i_rready = 1'b1;
    logic [3:0]  i_awid = '0, i_arid = '0;
    logic [7:0]  i_awaddr = '0, i_araddr = '0;
    logic [2:0]  i_awprot = '0, i_arprot = '0;
    logic [31:0] i_wdata = '0;
    logic [3:0]  i_wstrb = '0;
    logic        i_bus_ready = 1'b0;
    logic [1:0]  i_bus_status = '0;
    logic [31:0] i_bus_read_data = '0;
    logic        o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_bus_valid;
    logic [3:0]  o_bid, o_rid;
    logic [1:0]  o_bresp, o_rresp, o_bus_access;
    logic [31:0] o_rdata, o_bus_write_data;
    logic [7:0]  o_bus_address;
    logic [3:0]  o_bus_strobe;

    bus_exp_t exp_bus_q[$];
    bus_rsp_t bus_rsp_q[$];
    rsp_exp_t exp_b_q[$];
    rsp_exp_t exp_r_q[$];

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int grant_cyc = 0;
    bit lat_chk = 1'b0;
    bit prev_bvalid = 1'b0;

    rggen_axi4lite_regbus_bridge #(
        .ID_WIDTH      (4),
        .ADDRESS_WIDTH (8),
        .BUS_WIDTH     (32)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_awvalid        (i_awvalid),
        .o_awready        (o_awready),
        .i_awid           (i_awid),
        .i_awaddr         (i_awaddr),
        .i_awprot         (i_awprot),
        .i_wvalid         (i_wvalid),
        .o_wready         (o_wready),
        .i_wdata          (i_wdata),
        .i_wstrb          (i_wstrb),
        .o_bvalid         (o_bvalid),
        .i_bready         (i_bready),
        .o_bid            (o_bid),
        .o_bresp          (o_bresp),
        .i_arvalid        (i_arvalid),
        .o_arready        (o_arready),
        .i_arid           (i_arid),
        .i_araddr         (i_araddr),
        .i_arprot         (i_arprot),
        .o_rvalid         (o_rvalid),
        .i_rready         (i_rready),
        .o_rid            (o_rid),
        .o_rresp          (o_rresp),
        .o_rdata          (o_rdata),
        .o_bus_valid      (o_bus_valid),
        .o_bus_access     (o_bus_access),
        .o_bus_address    (o_bus_address),
        .o_bus_write_data (o_bus_write_data),
        .o_bus_strobe     (o_bus_strobe),
        .i_bus_ready      (i_bus_ready),
        .i_bus_status     (i_bus_status),
        .i_bus_read_data  (i_bus_read_data)
    );

    always #5 i_clk = ~i_clk;

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register-bus slave model: answers each request after its programmed wait count.
    initial begin
        int wc = 0;
        forever begin
            @(posedge i_clk);
            #1;
            i_bus_ready     = 1'b0;
            i_bus_status    = 2'b11;
            i_bus_read_data = 32'hBAD0_BAD0;
            if (o_bus_valid && bus_rsp_q.size() > 0) begin
                if (wc >= bus_rsp_q[0].waits) begin
                    i_bus_ready     = 1'b1;
                    i_bus_status    = bus_rsp_q[0].status;
                    i_bus_read_data = bus_rsp_q[0].rdata;
                    void'(bus_rsp_q.pop_front());
                    wc = 0;
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
        end
    end

    // Monitor: compares every cycle a request or response is presented, pops on handshake.
    initial begin
        bus_exp_t e;
        rsp_exp_t r;
        forever begin
            @(negedge i_clk);
            if (o_awready && i_awvalid && i_wvalid) grant_cyc = cyc;
            if (lat_chk && o_bvalid && !prev_bvalid) begin
                chk("b_latency", 64'(cyc - grant_cyc), 64'd2);
                lat_chk = 1'b0;
            end
            prev_bvalid = o_bvalid;
            if (o_bus_valid) begin
                if (exp_bus_q.size() == 0) begin
                    chk("bus_unexpected", 1, 0);
                end else begin
                    e = exp_bus_q[0];
                    chk("bus_access", o_bus_access, e.acc);
                    chk("bus_address", o_bus_address, e.addr);
                    chk("bus_write_data", o_bus_write_data, e.data);
                    chk("bus_strobe", o_bus_strobe, e.strb);
                    if (i_bus_ready) void'(exp_bus_q.pop_front());
                end
            end
            if (o_bvalid) begin
                if (exp_b_q.size() == 0) begin
                    chk("b_unexpected", 1, 0);
                end else begin
                    r = exp_b_q[0];
                    chk("bid", o_bid, r.id);
                    chk("bresp", o_bresp, r.resp);
                    if (i_bready) void'(exp_b_q.pop_front());
                end
            end
            if (o_rvalid) begin
                if (exp_r_q.size() == 0) begin
                    chk("r_unexpected", 1, 0);
                end else begin
                    r = exp_r_q[0];
                    chk("rid", o_rid, r.id);
                    chk("rresp", o_rresp, r.resp);
                    chk("rdata", o_rdata, r.data);
                    if (i_rready) void'(exp_r_q.pop_front());
                end
            end else begin
                chk("rdata_idle", o_rdata, 0);
            end
            if (o_bvalid && o_rvalid) chk("b_r_overlap", 1, 0);
        end
    end

    task automatic exp_write(input logic [3:0] id, input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int waits, input logic [1:0] status,
                             input logic [1:0] resp);
        exp_bus_q.push_back('{acc: 2'b11, addr: addr, data: data, strb: strb});
        bus_rsp_q.push_back('{waits: waits, status: status, rdata: 32'h7777_7777});
        exp_b_q.push_back('{id: id, resp: resp, data: 32'h0});
    endtask

    task automatic exp_read(input logic [3:0] id, input logic [7:0] addr, input int waits,
                            input logic [1:0] status, input logic [31:0] rdata,
                            input logic [1:0] resp);
        exp_bus_q.push_back('{acc: 2'b10, addr: addr, data: 32'h0, strb: 4'hF});
        bus_rsp_q.push_back('{waits: waits, status: status, rdata: rdata});
        exp_r_q.push_back('{id: id, resp: resp, data: rdata});
    endtask

    task automatic drv_write(input logic [3:0] id, input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        bit got = 1'b0;
        i_awvalid = 1'b1; i_awid = id; i_awaddr = addr; i_awprot = 3'b101;
        i_wvalid  = 1'b1; i_wdata = data; i_wstrb = strb;
        for (int n = 0; n < 200; n++) begin
            @(negedge i_clk);
            if (o_awready) begin
                got = 1'b1;
                break;
            end
        end
        chk("aw_grant", got, 1);
        if (got) chk("wready_with_awready", o_wready, 1);
        @(posedge i_clk);
        #1;
        i_awvalid = 1'b0;
        i_wvalid  = 1'b0;
    endtask

    task automatic drv_read(input logic [3:0] id, input logic [7:0] addr);
        bit got = 1'b0;
        i_arvalid = 1'b1; i_arid = id; i_araddr = addr; i_arprot = 3'b010;
        for (int n = 0; n < 200; n++) begin
            @(negedge i_clk);
            if (o_arready) begin
                got = 1'b1;
                break;
            end
        end
        chk("ar_grant", got, 1);
        @(posedge i_clk);
        #1;
        i_arvalid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (exp_bus_q.size() == 0 && exp_b_q.size() == 0 && exp_r_q.size() == 0) break;
            @(negedge i_clk);
        end
        chk("drain_bus", exp_bus_q.size(), 0);
        chk("drain_b", exp_b_q.size(), 0);
        chk("drain_r", exp_r_q.size(), 0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        exp_bus_q.delete();
        bus_rsp_q.delete();
        exp_b_q.delete();
        exp_r_q.delete();
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();
        @(negedge i_clk);
        chk("rst_awready", o_awready, 0);
        chk("rst_arready", o_arready, 0);
        chk("rst_bvalid", o_bvalid, 0);
        chk("rst_rvalid", o_rvalid, 0);
        chk("rst_bus_valid", o_bus_valid, 0);
        chk("rst_bus_access", o_bus_access, 0);
        chk("rst_bus_address", o_bus_address, 0);
        @(posedge i_clk);
        #1;

        // Single write, bus ready in first cycle, response 2 cycles after grant.
        exp_write(4'h3, 8'h10, 32'hDEAD_BEEF, 4'hF, 0, 2'b00, 2'b00);
        lat_chk = 1'b1;
        drv_write(4'h3, 8'h10, 32'hDEAD_BEEF, 4'hF);
        drain();
        chk("b_latency_seen", lat_chk, 0);

        // Read with 3 wait cycles and SLVERR.
        exp_read(4'h5, 8'h24, 3, 2'b10, 32'h1234_5678, 2'b10);
        drv_read(4'h5, 8'h24);
        drain();

        // AW alone must wait for W; then both readies rise together. Status 01 maps to OKAY.
        exp_write(4'h8, 8'h50, 32'h0BAD_F00D, 4'b0110, 2, 2'b01, 2'b00);
        i_awvalid = 1'b1; i_awid = 4'h8; i_awaddr = 8'h50;
        for (int n = 0; n < 5; n++) begin
            @(negedge i_clk);
            chk("aw_alone_awready", o_awready, 0);
            chk("aw_alone_wready", o_wready, 0);
        end
        @(posedge i_clk);
        #1;
        i_wvalid = 1'b1; i_wdata = 32'h0BAD_F00D; i_wstrb = 4'b0110;
        @(negedge i_clk);
        chk("aw_w_awready", o_awready, 1);
        chk("aw_w_wready", o_wready, 1);
        @(posedge i_clk);
        #1;
        i_awvalid = 1'b0;
        i_wvalid  = 1'b0;
        drain();

        // Contended read and write after reset: expect W,R,W,R.
        apply_reset();
        exp_write(4'h1, 8'h40, 32'h1111_1111, 4'hF, 0, 2'b00, 2'b00);
        exp_read(4'h2, 8'h44, 1, 2'b00, 32'hA5A5_A5A5, 2'b00);
        exp_write(4'h3, 8'h48, 32'h2222_3333, 4'h3, 0, 2'b10, 2'b10);
        exp_read(4'h4, 8'h4C, 0, 2'b11, 32'h0F0F_0F0F, 2'b11);
        fork
            begin
                drv_write(4'h1, 8'h40, 32'h1111_1111, 4'hF);
                drv_write(4'h3, 8'h48, 32'h2222_3333, 4'h3);
            end
            begin
                drv_read(4'h2, 8'h44);
                drv_read(4'h4, 8'h4C);
            end
        join
        drain();

        // Back-pressure on B: response held, pending read not granted.
        i_bready = 1'b0;
        exp_write(4'h6, 8'h30, 32'hCAFE_F00D, 4'hF, 1, 2'b11, 2'b11);
        drv_write(4'h6, 8'h30, 32'hCAFE_F00D, 4'hF);
        exp_read(4'h7, 8'h34, 0, 2'b00, 32'h55AA_55AA, 2'b00);
        i_arvalid = 1'b1; i_arid = 4'h7; i_araddr = 8'h34;
        for (int n = 0; n < 50; n++) begin
            @(negedge i_clk);
            if (o_bvalid) break;
        end
        chk("bp_bvalid_seen", o_bvalid, 1);
        for (int n = 0; n < 10; n++) begin
            @(negedge i_clk);
            chk("bp_bvalid_held", o_bvalid, 1);
            chk("bp_no_arready", o_arready, 0);
        end
        @(posedge i_clk);
        #1;
        i_bready = 1'b1;
        @(negedge i_clk);
        chk("bp_handshake_no_grant", o_arready, 0);
        drv_read(4'h7, 8'h34);
        drain();

        // Reset during BUS drops the access; the next access completes normally.
        exp_write(4'h9, 8'h60, 32'h1357_9BDF, 4'hF, 20, 2'b00, 2'b00);
        drv_write(4'h9, 8'h60, 32'h1357_9BDF, 4'hF);
        chk("mid_bus_valid_before", o_bus_valid, 1);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_bus_valid", o_bus_valid, 0);
        chk("mid_rst_bus_access", o_bus_access, 0);
        chk("mid_rst_bus_address", o_bus_address, 0);
        chk("mid_rst_bus_wdata", o_bus_write_data, 0);
        chk("mid_rst_bus_strobe", o_bus_strobe, 0);
        chk("mid_rst_bvalid", o_bvalid, 0);
        apply_reset();
        exp_read(4'hA, 8'h64, 0, 2'b00, 32'h2468_ACE0, 2'b00);
        drv_read(4'hA, 8'h64);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
